// File: rtl/sp_frame_rd.sv
// Frame reader for the SuperMario parallel port: drives SP_CLK/SP_NRST, packs
// sampled bytes into PACK-byte words and streams them out through a small FIFO.
module sp_frame_rd #(
  parameter int PACK    = 4,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4,
  parameter int FRAME_W = 16,
  parameter int RST_CYC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [8*PACK-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               SP_CLK,
  output logic               SP_NRST,
  input  logic [7:0]         SP_DOUT,
  input  logic               SP_UPDATE,
  input  logic               SP_EOF
);

  localparam int W     = 8 * PACK;
  localparam int KW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [KW-1:0]    K_LAST   = KW'(PACK - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, CHIPRST, RUN, DRAIN} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic [KW-1:0]      k;
  logic [W-1:0]       pack_word;
  logic [W-1:0]       word_nxt;
  logic               vld_p0;
  logic               eof_p0;
  logic [7:0]         data_p0;

  logic [W:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      mcount;
  logic [CW-1:0]      total;
  logic               full;
  logic               pop;
  logic               load;
  logic               push;
  logic               rise;
  logic               drain_done;

  // Occupancy counts the word parked in the output register as well.
  assign total      = mcount + CW'(dout_valid);
  assign full       = (total >= FULL_CNT);
  assign pop        = dout_valid & dout_ready;
  assign load       = (~dout_valid | pop) & (mcount != '0);
  assign push       = vld_p0 & (eof_p0 | (k == K_LAST));
  assign rise       = (state == RUN) & (div_cnt == DIV_LAST) & ~SP_CLK & ~full;
  assign drain_done = (mcount == '0) & (~dout_valid | pop);

  always_comb begin
    word_nxt = pack_word;
    for (int i = 0; i < PACK; i++) begin
      if (k == KW'(i)) word_nxt[8*i +: 8] = data_p0;
    end
  end

  // Stage p0: byte captured on the clk edge that raises SP_CLK.
  always_ff @(posedge clk) begin
    if (rise) data_p0 <= SP_DOUT;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {eof_p0, word_nxt};
  end

  // Stage p1: packer update / FIFO push; head word registered one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mcount     <= '0;
      dout       <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        {dout_last, dout} <= mem[rd_ptr];
        rd_ptr            <= rd_ptr + 1'b1;
        dout_valid        <= 1'b1;
      end else if (pop) begin
        dout_valid <= 1'b0;
      end
      mcount <= mcount + CW'(push) - CW'(load);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      SP_CLK    <= 1'b0;
      SP_NRST   <= 1'b0;
      frame_cnt <= '0;
      k         <= '0;
      pack_word <= '0;
      vld_p0    <= 1'b0;
      eof_p0    <= 1'b0;
      div_cnt   <= '0;
      rst_cnt   <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          SP_CLK  <= 1'b0;
          SP_NRST <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            frame_cnt <= '0;
            k         <= '0;
            pack_word <= '0;
            rst_cnt   <= '0;
            state     <= CHIPRST;
          end
        end
        CHIPRST: begin
          if (rst_cnt == RST_LAST) begin
            SP_NRST <= 1'b1;
            div_cnt <= '0;
            state   <= RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (SP_CLK) begin
            SP_CLK  <= 1'b0;
            div_cnt <= '0;
          end else if (!full) begin
            SP_CLK  <= 1'b1;
            div_cnt <= '0;
            vld_p0  <= SP_UPDATE;
            eof_p0  <= SP_EOF;
          end
          if (vld_p0) begin
            if (push) begin
              k         <= '0;
              pack_word <= '0;
            end else begin
              k         <= k + 1'b1;
              pack_word <= word_nxt;
            end
            if (eof_p0) begin
              frame_cnt <= frame_cnt + 1'b1;
              if (!continuous) begin
                SP_CLK <= 1'b0;
                state  <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            busy    <= 1'b0;
            SP_NRST <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_frame_rd.sv
// Bench for sp_frame_rd: a queue-driven chip model feeds bytes, a monitor
// collects output words, and a chunking reference model predicts them.
module tb_sp_frame_rd;
  localparam int PACK = 4, DEPTH = 4, CLK_DIV = 2, FRAME_W = 16, RST_CYC = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               continuous = 1'b0;
  logic               busy;
  logic [FRAME_W-1:0] frame_cnt;
  logic [8*PACK-1:0]  dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;
  logic               SP_CLK;
  logic               SP_NRST;
  logic [7:0]         SP_DOUT;
  logic               SP_UPDATE;
  logic               SP_EOF;

  sp_frame_rd #(.PACK(PACK), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .FRAME_W(FRAME_W),
                .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .busy(busy),
    .frame_cnt(frame_cnt), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .SP_CLK(SP_CLK),
    .SP_NRST(SP_NRST), .SP_DOUT(SP_DOUT), .SP_UPDATE(SP_UPDATE), .SP_EOF(SP_EOF));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;
  int pop_t = 0;
  int nrst_rises = 0;
  int rise_t[$];
  logic [9:0]  chip_q[$];
  logic [7:0]  fbytes[$];
  logic [32:0] exp_q[$];
  logic [32:0] got[$];

  typedef struct {
    int          n;
    logic [7:0]  b0;
    int          nw;
    logic [31:0] w0;
    logic [31:0] wl;
  } vec_t;
  vec_t vt[6];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Chip model and output monitor
  initial begin
    logic prev_clk;
    logic prev_nrst;
    prev_clk = 1'b0;
    prev_nrst = 1'b0;
    {SP_UPDATE, SP_EOF, SP_DOUT} = '0;
    forever begin
      @(negedge clk);
      if (SP_CLK && !prev_clk) begin
        rise_t.push_back(cyc);
        if (chip_q.size() > 0) chip_q.delete(0);
      end
      prev_clk = SP_CLK;
      if (SP_NRST && !prev_nrst) nrst_rises++;
      prev_nrst = SP_NRST;
      if (chip_q.size() > 0) {SP_UPDATE, SP_EOF, SP_DOUT} = chip_q[0];
      else {SP_UPDATE, SP_EOF, SP_DOUT} = '0;
      if (dout_valid && dout_ready) begin
        got.push_back({dout_last, dout});
        pop_t = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic void ref_frame();
    int n = fbytes.size();
    for (int i = 0; i < n; i += PACK) begin
      logic [31:0] w = '0;
      for (int j = 0; j < PACK; j++) if (i + j < n) w[8*j +: 8] = fbytes[i+j];
      exp_q.push_back({(i + PACK >= n), w});
    end
  endfunction

  task automatic add_frame(input bit gaps);
    for (int i = 0; i < fbytes.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        chip_q.push_back({1'b0, 1'($urandom_range(0, 1)), 8'($urandom)});
      chip_q.push_back({1'b1, (i == fbytes.size() - 1), fbytes[i]});
    end
  endtask

  task automatic compare_words(input string nm, input int base);
    logic [63:0] a;
    chk({nm, "_count"}, 64'(got.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (base + i < got.size()) ? 64'(got[base+i]) : 'x;
      chk(nm, a, 64'(exp_q[i]));
    end
  endtask

  task automatic pulse_start(output int t_acc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    t_acc = cyc;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int t_acc, r0, base, n, r100, nl, nfr, t;
    vt[0] = '{8, 8'h01, 2, 32'h04030201, 32'h08070605};
    vt[1] = '{6, 8'hA1, 2, 32'hA4A3A2A1, 32'h0000A6A5};
    vt[2] = '{1, 8'h5A, 1, 32'h0000005A, 32'h0000005A};
    vt[3] = '{4, 8'h10, 1, 32'h13121110, 32'h13121110};
    vt[4] = '{3, 8'hF0, 1, 32'h00F2F1F0, 32'h00F2F1F0};
    vt[5] = '{5, 8'hFE, 2, 32'h0100FFFE, 32'h00000002};

    repeat (3) @(negedge clk);
    chk("rst_sp_clk", 64'(SP_CLK), 0);
    chk("rst_sp_nrst", 64'(SP_NRST), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_frame_cnt", 64'(frame_cnt), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_dout_valid", 64'(dout_valid), 0);
    chk("rst_dout_last", 64'(dout_last), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven single frames, first one with cycle-exact timing
    for (int i = 0; i < 6; i++) begin
      fbytes.delete(); exp_q.delete();
      for (int j = 0; j < vt[i].n; j++) fbytes.push_back(8'(vt[i].b0 + 8'(j)));
      ref_frame();
      add_frame(1'b0);
      base = got.size();
      r0 = rise_t.size();
      pulse_start(t_acc);
      chk("busy_after_start", 64'(busy), 1);
      if (i == 0) begin
        n = 0;
        while (!SP_NRST && n < 100) begin @(negedge clk); n++; end
        chk("nrst_rise_delay", 64'(cyc - t_acc), 64'(RST_CYC));
        n = 0;
        while (!dout_valid && n < 200) begin @(negedge clk); n++; end
        t = cyc;
        chk("first_spclk_rise", 64'(rise_t[r0] - t_acc), 64'(RST_CYC + CLK_DIV));
        chk("spclk_period", 64'(rise_t[r0+1] - rise_t[r0]), 64'(2 * CLK_DIV));
        chk("dout_valid_delay", 64'(t - rise_t[r0+3]), 2);
        n = 0;
        while (frame_cnt != 1 && n < 200) begin @(negedge clk); n++; end
        chk("frame_cnt_delay", 64'(cyc - rise_t[r0+7]), 1);
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("busy_fall_delay", 64'(cyc - pop_t), 1);
      end
      wait_idle("vec", 1000);
      chk("vec_nwords", 64'(got.size() - base), 64'(vt[i].nw));
      chk("vec_first", 64'(got[base]), 64'({(vt[i].nw == 1), vt[i].w0}));
      chk("vec_final", 64'(got[base + vt[i].nw - 1]), 64'({1'b1, vt[i].wl}));
      chk("vec_frame_cnt", 64'(frame_cnt), 1);
      compare_words("vec_ref", base);
    end

    // Back-pressure: FIFO fills, SP_CLK stalls low, nothing lost
    ready_mode = 0;
    fbytes.delete(); exp_q.delete();
    for (int j = 0; j < 24; j++) fbytes.push_back(8'(j * 7 + 3));
    ref_frame();
    add_frame(1'b0);
    base = got.size();
    r0 = rise_t.size();
    pulse_start(t_acc);
    repeat (100) @(negedge clk);
    r100 = rise_t.size();
    repeat (100) @(negedge clk);
    chk("bp_rises", 64'(rise_t.size() - r0), 64'(DEPTH * PACK));
    chk("bp_no_new_rise", 64'(rise_t.size()), 64'(r100));
    chk("bp_spclk_low", 64'(SP_CLK), 0);
    chk("bp_valid", 64'(dout_valid), 1);
    chk("bp_none_popped", 64'(got.size() - base), 0);
    ready_mode = 1;
    wait_idle("bp", 2000);
    compare_words("bp_ref", base);
    chk("bp_frame_cnt", 64'(frame_cnt), 1);

    // Continuous 3 frames; a start during RUN is ignored
    fbytes.delete(); exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      fbytes.delete();
      for (int j = 0; j < 4; j++) fbytes.push_back(8'(8'hC0 + 8'(16 * f + j)));
      ref_frame();
      add_frame(1'b0);
    end
    continuous = 1'b1;
    base = got.size();
    nl = nrst_rises;
    pulse_start(t_acc);
    n = 0;
    while (frame_cnt != 1 && n < 500) begin @(negedge clk); n++; end
    pulse_start(t);
    chk("restart_frame_cnt", 64'(frame_cnt), 1);
    chk("restart_busy", 64'(busy), 1);
    chk("restart_nrst", 64'(SP_NRST), 1);
    n = 0;
    while (frame_cnt != 2 && n < 500) begin @(negedge clk); n++; end
    continuous = 1'b0;
    wait_idle("cont", 1000);
    chk("cont_frame_cnt", 64'(frame_cnt), 3);
    chk("cont_nrst_rises", 64'(nrst_rises - nl), 1);
    t = 0;
    for (int i = base; i < got.size(); i++) t += int'(got[i][32]);
    chk("cont_last_words", 64'(t), 3);
    compare_words("cont_ref", base);

    // Reset in the middle of a frame, then a clean frame
    fbytes.delete(); exp_q.delete();
    for (int j = 0; j < 8; j++) fbytes.push_back(8'(8'h11 + 8'(j)));
    add_frame(1'b0);
    r0 = rise_t.size();
    pulse_start(t_acc);
    n = 0;
    while (rise_t.size() - r0 < 2 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_nrst", 64'(SP_NRST), 0);
    chk("mid_rst_valid", 64'(dout_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_spclk", 64'(SP_CLK), 0);
    chip_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    fbytes.delete(); exp_q.delete();
    for (int j = 0; j < 4; j++) fbytes.push_back(8'(8'hB1 + 8'(j)));
    ref_frame();
    add_frame(1'b0);
    base = got.size();
    pulse_start(t_acc);
    wait_idle("post_rst", 1000);
    compare_words("post_rst_ref", base);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 1);

    // Randomized runs against the reference model
    for (int it = 0; it < 8; it++) begin
      ready_mode = 2;
      nfr = $urandom_range(1, 3);
      fbytes.delete(); exp_q.delete();
      for (int f = 0; f < nfr; f++) begin
        fbytes.delete();
        t = $urandom_range(1, 11);
        for (int j = 0; j < t; j++) fbytes.push_back(8'($urandom));
        ref_frame();
        add_frame(1'b1);
      end
      continuous = (nfr > 1);
      base = got.size();
      pulse_start(t_acc);
      n = 0;
      while (busy && n < 4000) begin
        @(negedge clk);
        n++;
        if (frame_cnt == FRAME_W'(nfr - 1)) continuous = 1'b0;
      end
      chk("rnd_idle_timeout", 64'(busy), 0);
      chk("rnd_frame_cnt", 64'(frame_cnt), 64'(nfr));
      chk("rnd_chip_consumed", 64'(chip_q.size()), 0);
      compare_words("rnd_ref", base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_frame_rd.md
# sp_frame_rd

Parametrised frame reader for the SuperMario chip's parallel output port. It drives the chip clock and reset and samples SP_DOUT bytes qualified by SP_UPDATE. Bytes are packed into PACK-byte words, buffered in a DEPTH-word FIFO, and presented on a valid/ready stream with a frame-end marker. Single-shot and continuous frame modes are supported, and the chip clock is stalled when the FIFO fills, so no data is ever dropped.

## Interface
- PACK, 4: bytes per output word (1..4); output width is 8*PACK.
- DEPTH, 16: FIFO depth in words (power of 2, ≥2).
- CLK_DIV, 4: SP_CLK half-period in clk cycles (≥1).
- FRAME_W, 16: width of the frame counter.
- RST_CYC, 8: clk cycles SP_NRST is held low before the first frame.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a capture; ignored while busy.
- continuous  in  1  sampled at every frame end: 1 = run the next frame, 0 = stop.
- busy  out  1  high from the start accept until IDLE is re-entered.
- frame_cnt  out  FRAME_W  completed frames since the last start; wraps.
- dout  out  8*PACK  FIFO head word; first byte in bits [7:0].
- dout_valid  out  1  head word valid.
- dout_ready  in  1  consumer accepts the head word when dout_valid & dout_ready.
- dout_last  out  1  head word is the final word of a frame.
- SP_CLK  out  1  chip clock, a registered output.
- SP_NRST  out  1  chip reset, active-low, a registered output.
- SP_DOUT  in  8  chip byte output.
- SP_UPDATE  in  1  SP_DOUT holds a valid byte.
- SP_EOF  in  1  the current byte is the last byte of the frame; meaningful only with SP_UPDATE.

## Operation
- FSM states: IDLE, CHIPRST, RUN, DRAIN.
- IDLE: SP_CLK=0, SP_NRST=0. A start pulse clears frame_cnt and the packer, then moves to CHIPRST.
- CHIPRST: SP_NRST stays low for RST_CYC cycles, then goes high; the FSM then moves to RUN.
- RUN: SP_CLK toggles every CLK_DIV cycles.
  - A rising edge is issued only if the FIFO is not full. Otherwise SP_CLK holds low until space frees.
  - In the cycle SP_CLK rises, SP_UPDATE, SP_EOF and SP_DOUT are sampled.
  - If SP_UPDATE=1, the byte is appended to the packer at byte index k (k counts 0..PACK-1).
- Packer push rules:
  - When k reaches PACK-1, the word is pushed with last=0.
  - When an update arrives with SP_EOF=1, the (possibly partial) word is pushed with last=1. Unfilled upper bytes are 0. k resets to 0 and frame_cnt increments.
  - If the EOF byte also completes the word, exactly one push occurs, with last=1.
- Frame end:
  - continuous=1: remain in RUN and start the next frame; the chip is not reset.
  - continuous=0: go to DRAIN with SP_CLK held low.
- SP_EOF with SP_UPDATE=0 is ignored.
- DRAIN: wait until the FIFO is empty (the last word has been accepted), then enter IDLE. SP_NRST stays high until IDLE.
- FIFO: first-word-fall-through. A simultaneous push and pop is legal at any count.
- start while busy has no effect.
- rst at any time, including mid-frame:
  - FIFO emptied, packer cleared, FSM to IDLE.
  - All outputs take their reset values on the next clock edge after rst asserts, or asynchronously.

## Timing
- Reset values: SP_CLK=0, SP_NRST=0, busy=0, frame_cnt=0, dout=0, dout_valid=0, dout_last=0.
- busy rises 1 cycle after start is accepted.
- SP_NRST rises RST_CYC cycles after entering CHIPRST. The first SP_CLK rise occurs CLK_DIV cycles after that.
- With the FIFO not full, the SP_CLK period is 2*CLK_DIV cycles.
- Sampling happens on the clk edge that sets SP_CLK to 1. The push occurs on the next clk edge.
- dout_valid rises 2 clk cycles after the SP_CLK rise that completes the word (FIFO empty, dout_ready don't-care).
- frame_cnt updates in the same cycle as the push that carries last=1.
- busy falls in the cycle after the final pop in DRAIN.

## Test plan
- PACK=4, CLK_DIV=2, dout_ready=1; chip sends bytes 01..08 with EOF on 08.
  - Expect words 0x04030201 (last=0) and 0x08070605 (last=1).
  - Expect frame_cnt=1, then busy falls.
- PACK=4; a frame of 6 bytes A1..A6.
  - Expect 0x A4A3A2A1, then 0x0000A6A5 with last=1.
- DEPTH=4, dout_ready=0 for 200 cycles.
  - Expect exactly 4 words buffered and SP_CLK held low with no rising edges.
  - After dout_ready=1, all words arrive in order with no byte lost.
- continuous=1 for 3 frames of 4 bytes, then continuous=0.
  - Expect 3 last-marked words, frame_cnt=3, and SP_NRST low only once (during CHIPRST).
- Apply rst mid-frame after 2 bytes.
  - Expect SP_NRST=0, dout_valid=0, busy=0 immediately.
  - A following start yields a clean frame with no stale bytes.
- A second start pulse during RUN is ignored: frame_cnt is not cleared and the FSM state is unchanged.
